// File: rtl/halt_request_gen.sv
// Halt-code producer for the clock-gating stage: drains, halts, single-steps, resumes.
// Optional HALT_WATCHDOG_EN adds an auto-resume after WD_LIMIT halted cycles (wd_fired sticky).
module halt_request_gen #(
  parameter int unsigned    OPW          = 4,
  parameter logic [OPW-1:0] HALT_OPCODE  = 4'hF,
  parameter int unsigned    DRAIN_CYCLES = 2,
  parameter int unsigned    CW           = 16
`ifdef HALT_WATCHDOG_EN
  ,
  parameter int unsigned    WD_LIMIT     = 1000
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           opcode_valid,
  input  logic [OPW-1:0] opcode,
  input  logic           resume_req,
  input  logic           step_req,
  output logic [1:0]     instruction_to_halt,
  output logic           halted,
  output logic           resume_ack,
`ifdef HALT_WATCHDOG_EN
  output logic           wd_fired,
`endif
  output logic [CW-1:0]  halt_count
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP_WAIT} state_e;

  state_e        state_q, state_d;
  logic [3:0]    drain_q, drain_d;
  logic [CW-1:0] count_q, count_d;
  logic          armed_q, armed_d;
  logic          ack_q, ack_d;
  logic [1:0]    code_q, code_d;
  logic          halted_q, halted_d;
  logic          wd_q, wd_d;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    count_d = count_q;
    armed_d = armed_q;
    ack_d   = 1'b0;
    wd_d    = wd_q;
    case (state_q)
      RUN: begin
        if (!resume_req) armed_d = 1'b1;
        if (opcode_valid && opcode == HALT_OPCODE && armed_q) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = HALTED;
            count_d = '0;
          end else begin
            state_d = DRAIN;
            drain_d = 4'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        if (drain_q <= 4'd1) begin
          state_d = HALTED;
          drain_d = '0;
          count_d = '0;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      HALTED: begin
        // The exit edge back to RUN leaves the count frozen at its last shown value.
        if (count_q != '1) count_d = count_q + 1'b1;
`ifdef HALT_WATCHDOG_EN
        if (count_q == CW'(WD_LIMIT)) begin
          state_d = RUN;
          count_d = count_q;
          ack_d   = 1'b1;
          wd_d    = 1'b1;
          armed_d = 1'b1;
        end else
`endif
        if (resume_req) begin
          state_d = RUN;
          count_d = count_q;
          ack_d   = 1'b1;
          armed_d = 1'b0;
        end else if (step_req) begin
          state_d = STEP_WAIT;
        end
      end
      STEP_WAIT: state_d = HALTED;
      default:   state_d = RUN;
    endcase
    code_d   = (state_d == HALTED) ? 2'b10 : 2'b00;
    halted_d = (state_d == HALTED) || (state_d == STEP_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      drain_q  <= '0;
      count_q  <= '0;
      armed_q  <= 1'b1;
      ack_q    <= 1'b0;
      code_q   <= 2'b00;
      halted_q <= 1'b0;
      wd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      count_q  <= count_d;
      armed_q  <= armed_d;
      ack_q    <= ack_d;
      code_q   <= code_d;
      halted_q <= halted_d;
      wd_q     <= wd_d;
    end
  end

  assign instruction_to_halt = code_q;
  assign halted              = halted_q;
  assign resume_ack          = ack_q;
  assign halt_count          = count_q;
`ifdef HALT_WATCHDOG_EN
  assign wd_fired            = wd_q;
`else
  logic unused_wd;
  assign unused_wd = wd_q;
`endif

endmodule
